// File: rtl/shifter_pkg.sv
// Shared mode codes and decode helpers for the pipelined barrel shifter.
package shifter_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    M_SLL = 3'b000,
    M_SRL = 3'b001,
    M_SRA = 3'b010,
    M_ROL = 3'b011,
    M_ROR = 3'b100
  } mode_e;

  // Left-going ops run through the right-shift datapath bit-reversed.
  function automatic logic is_left(input logic [MODE_W-1:0] m);
    return (m == M_SLL) || (m == M_ROL);
  endfunction

  function automatic logic is_rsvd(input logic [MODE_W-1:0] m);
    return m > M_ROR;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered right-shift stage: shifts by DIST when its amount bit is set,
// holds all state while en is low.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic [MODE_W-1:0]          in_mode,
  input  logic                       in_sign,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(WIDTH)-1:0]   out_amt,
  output logic [MODE_W-1:0]          out_mode,
  output logic                       out_sign
);

  localparam int BIT = $clog2(DIST);

  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = in_data;
    if (in_amt[BIT]) begin
      case (mode_e'(in_mode))
        M_SRA:        nxt = {{DIST{in_sign}}, in_data[WIDTH-1:DIST]};
        M_ROL, M_ROR: nxt = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
        default:      nxt = {{DIST{1'b0}}, in_data[WIDTH-1:DIST]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_mode  <= M_SLL;
      out_sign  <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= nxt;
      out_amt   <= in_amt;
      out_mode  <= in_mode;
      out_sign  <= in_sign;
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// SHW-stage pipelined shifter/rotator with valid/ready handshake and a
// global stall when the output is held.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHW-1:0]     in_amt,
  input  logic [MODE_W-1:0]  in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err
);

  logic                        stall;
  logic [SHW:0]                vld_pipe;
  logic [SHW:0][WIDTH-1:0]     dat_pipe;
  logic [SHW:0][SHW-1:0]       amt_pipe;
  logic [SHW:0][MODE_W-1:0]    mode_pipe;
  logic [SHW:0]                sgn_pipe;
  logic [WIDTH-1:0]            rev_in;
  logic [WIDTH-1:0]            rev_out;

  assign stall    = vld_pipe[SHW] && !out_ready;
  assign in_ready = !stall;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign rev_in[i]  = in_data[WIDTH-1-i];
    assign rev_out[i] = dat_pipe[SHW][WIDTH-1-i];
  end

  // Reserved modes pass data through untouched, so their amount is dropped.
  assign vld_pipe[0]  = in_valid;
  assign dat_pipe[0]  = is_left(in_mode) ? rev_in : in_data;
  assign amt_pipe[0]  = is_rsvd(in_mode) ? '0 : in_amt;
  assign mode_pipe[0] = in_mode;
  assign sgn_pipe[0]  = in_data[WIDTH-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .DIST(1 << k)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .en        (!stall),
      .in_valid  (vld_pipe[k]),
      .in_data   (dat_pipe[k]),
      .in_amt    (amt_pipe[k]),
      .in_mode   (mode_pipe[k]),
      .in_sign   (sgn_pipe[k]),
      .out_valid (vld_pipe[k+1]),
      .out_data  (dat_pipe[k+1]),
      .out_amt   (amt_pipe[k+1]),
      .out_mode  (mode_pipe[k+1]),
      .out_sign  (sgn_pipe[k+1])
    );
  end

  assign out_valid = vld_pipe[SHW];
  assign out_data  = is_left(mode_pipe[SHW]) ? rev_out : dat_pipe[SHW];
  assign out_err   = is_rsvd(mode_pipe[SHW]);

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter (WIDTH=32): directed cases plus a random
// stream with random backpressure, all checked against a behavioural model.
module tb_pipe_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  pipe_shifter #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    logic        lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic lat_chk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_data(input logic [31:0] d, input logic [4:0] a,
                                           input logic [2:0] m);
    logic [5:0] inv;
    inv = 6'd32 - {1'b0, a};
    case (m)
      3'd0: return d << a;
      3'd1: return d >> a;
      3'd2: return 32'($signed(d) >>> a);
      3'd3: return (a == 5'd0) ? d : ((d << a) | (d >> inv));
      3'd4: return (a == 5'd0) ? d : ((d >> a) | (d << inv));
      default: return d;
    endcase
  endfunction

  // One cycle: drive at negedge, then evaluate what the next posedge will do.
  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] a,
                      input logic [2:0] m, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    in_mode   = m;
    out_ready = ordy;
    #1;
    if (out_valid && !out_ready && sb.size() > 0) begin
      chk("hold_data", out_data, sb[0].data);
      chk("stall_ready", in_ready, 0);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        e = sb.pop_front();
        chk("data", out_data, e.data);
        chk("err", out_err, e.err);
        if (e.lat) chk("latency", cyc - e.cyc, 5);
      end
    end
    if (in_valid && in_ready)
      sb.push_back('{ref_data(d, a, m), (m > 3'd4), cyc, lat_chk});
    cyc++;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) step(1'b0, 32'h0, 5'd0, 3'd0, 1'b1);
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 1);

    // SRA sign fill with latency check, then back-to-back rotates.
    lat_chk = 1'b1;
    step(1'b1, 32'h8000_0000, 5'd31, 3'd2, 1'b1);
    drain(20);
    step(1'b1, 32'h0000_0001, 5'd1, 3'd4, 1'b1);
    step(1'b1, 32'h8000_0000, 5'd1, 3'd3, 1'b1);
    drain(20);
    lat_chk = 1'b0;

    // SLL held under 10 cycles of backpressure.
    step(1'b1, 32'h0000_FFFF, 5'd16, 3'd0, 1'b0);
    repeat (10) step(1'b0, 32'h0, 5'd0, 3'd0, 1'b0);
    chk("stall_valid", out_valid, 1);
    drain(20);

    // Reserved mode passthrough and amount-0 across all modes.
    step(1'b1, 32'h1234_5678, 5'd7, 3'd7, 1'b1);
    for (int m = 0; m < 8; m++) step(1'b1, 32'hA5C3_0F96, 5'd0, m[2:0], 1'b1);
    drain(20);

    // Reset with requests in flight: nothing may come out afterwards.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + i, 5'(i), 3'd1, 1'b1);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_err", out_err, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
    end

    // Random stream with random backpressure.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, $urandom, a, 3'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0);
    end
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
